// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master side drives the request; the slave side returns the status and the result.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             C;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] S;
   logic             Carry;

   modport master (output start, A, B, C, input busy, done, S, Carry);
   modport slave  (input start, A, B, C, output busy, done, S, Carry);
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder is reused once per bit, LSB first.
// A result is ready WIDTH cycles after start is accepted.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   serial_adder_ctrl_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, res, res_nxt;
   logic             cy;
   logic [CW-1:0]    cnt;
   logic             fa_s, fa_co;
   logic             last;
   logic             accept;

   FullAdder u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (cy),
      .s  (fa_s),
      .co (fa_co)
   );

   assign last   = (cnt == LAST);
   assign accept = (state != RUN) && bus.start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last) state_nxt = DONE;
         DONE:    state_nxt = bus.start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state == RUN);
      bus.done = (state == DONE);
   end

   // New sum bit enters from the MSB side so bit 0 ends up at S[0].
   always_comb begin
      res_nxt            = res >> 1;
      res_nxt[WIDTH-1]   = fa_s;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh      <= '0;
         b_sh      <= '0;
         res       <= '0;
         cy        <= 1'b0;
         cnt       <= '0;
         bus.S     <= '0;
         bus.Carry <= 1'b0;
      end else if (accept) begin
         a_sh <= bus.A;
         b_sh <= bus.B;
         cy   <= bus.C;
         cnt  <= '0;
      end else if (state == RUN) begin
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
         res  <= res_nxt;
         cy   <= fa_co;
         cnt  <= cnt + 1'b1;
         if (last) begin
            bus.S     <= res_nxt;
            bus.Carry <= fa_co;
         end
      end
   end
endmodule

module FullAdder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: table vectors, corner sequences and random ops,
// checked against a cycle model with a result queue.
module tb_serial_adder_ctrl;
   logic clk;
   logic rst;

   serial_adder_ctrl_if #(.WIDTH(8)) bus ();
   serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

   serial_adder_ctrl #(.WIDTH(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
   serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Cycle model of the 8-bit instance.
   int         m_run = 0;
   bit         m_done = 1'b0;
   logic [8:0] q[$];
   logic [7:0] exp_s = '0;
   logic       exp_c = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_run  = 0;
         m_done = 1'b0;
         q.delete();
         exp_s  = '0;
         exp_c  = 1'b0;
      end else if (m_run > 0) begin
         m_run = m_run - 1;
         if (m_run == 0) begin
            m_done = 1'b1;
            if (q.size() > 0) {exp_c, exp_s} = q.pop_front();
         end
      end else begin
         m_done = 1'b0;
         if (bus.start) begin
            q.push_back({1'b0, bus.A} + {1'b0, bus.B} + {8'd0, bus.C});
            m_run = 8;
         end
      end
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic [7:0] s;
      logic       carry;
   } vec_t;

   vec_t tbl[7];

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check("busy", 32'(bus.busy), 32'(m_run > 0));
      check("done", 32'(bus.done), 32'(m_done));
      check("S", 32'(bus.S), 32'(exp_s));
      check("Carry", 32'(bus.Carry), 32'(exp_c));
   endtask

   task automatic wait_done(output bit got);
      got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         tick();
         if (bus.done) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL done_timeout: got no done, expected one within 12 cycles");
      end
   endtask

   task automatic do_op(logic [7:0] a, logic [7:0] b, logic c);
      bit got;
      bus.start = 1'b1;
      bus.A = a;
      bus.B = b;
      bus.C = c;
      tick();
      bus.start = 1'b0;
      bus.A = 8'($urandom);
      bus.B = 8'($urandom);
      bus.C = 1'($urandom);
      wait_done(got);
   endtask

   initial begin
      tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      tbl[1] = '{8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0};
      tbl[2] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
      tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      tbl[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
      tbl[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

      rst = 1'b1;
      bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.C = 1'b0;
      bus1.start = 1'b0; bus1.A = '0; bus1.B = '0; bus1.C = 1'b0;
      tick();
      tick();
      check("rst_S1", 32'(bus1.S), 32'd0);
      check("rst_busy1", 32'(bus1.busy), 32'd0);
      rst = 1'b0;
      tick();

      // Table vectors, applied back to back from DONE.
      foreach (tbl[i]) begin
         do_op(tbl[i].a, tbl[i].b, tbl[i].c);
         check("tbl_S", 32'(bus.S), 32'(tbl[i].s));
         check("tbl_Carry", 32'(bus.Carry), 32'(tbl[i].carry));
      end

      // FF+01: busy for exactly eight cycles, done on the ninth.
      tick();
      begin
         int nbusy = 0;
         int done_at = -1;
         bus.start = 1'b1; bus.A = 8'hFF; bus.B = 8'h01; bus.C = 1'b0;
         for (int i = 1; i <= 10; i++) begin
            tick();
            bus.start = 1'b0;
            if (bus.busy) nbusy++;
            if (bus.done && done_at < 0) done_at = i;
         end
         check("ff01_busy_cycles", 32'(nbusy), 32'd8);
         check("ff01_done_cycle", 32'(done_at), 32'd9);
         check("ff01_S", 32'(bus.S), 32'h00);
         check("ff01_Carry", 32'(bus.Carry), 32'd1);
      end

      // 5A+33+1, then hold for ten idle cycles.
      do_op(8'h5A, 8'h33, 1'b1);
      for (int i = 0; i < 10; i++) tick();
      check("hold_S", 32'(bus.S), 32'h8E);
      check("hold_Carry", 32'(bus.Carry), 32'd0);

      // start held high for 20 cycles; operands scrambled while running.
      begin
         int ndone = 0;
         bus.start = 1'b1; bus.A = 8'h10; bus.B = 8'h20; bus.C = 1'b0;
         for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done) begin
               ndone++;
               check("b2b_S", 32'(bus.S), 32'h30);
            end
            if (m_run > 1) begin
               bus.A = 8'($urandom); bus.B = 8'($urandom); bus.C = 1'($urandom);
            end else begin
               bus.A = 8'h10; bus.B = 8'h20; bus.C = 1'b0;
            end
         end
         bus.start = 1'b0;
         check("b2b_count", 32'(ndone), 32'd2);
      end
      for (int i = 0; i < 12; i++) tick();

      // Reset in the third RUN cycle, then start while rst is released.
      bus.start = 1'b1; bus.A = 8'h12; bus.B = 8'h34; bus.C = 1'b0;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_done", 32'(bus.done), 32'd0);
      check("arst_S", 32'(bus.S), 32'd0);
      check("arst_Carry", 32'(bus.Carry), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      bus.start = 1'b1; bus.A = 8'h80; bus.B = 8'h80; bus.C = 1'b1;
      tick();
      check("rst_release_accept", 32'(bus.busy), 32'd1);
      bus.start = 1'b0;
      begin
         bit got;
         wait_done(got);
      end
      check("post_rst_S", 32'(bus.S), 32'h01);
      check("post_rst_Carry", 32'(bus.Carry), 32'd1);

      // Random operations, some back to back, some with idle gaps.
      for (int n = 0; n < 1000; n++) begin
         do_op(8'($urandom), 8'($urandom), 1'($urandom));
         if ($urandom_range(0, 3) == 0) tick();
      end
      tick();
      tick();
      check("queue_empty", 32'(q.size()), 32'd0);

      // WIDTH=1 instance: 1+1+1.
      bus1.start = 1'b1; bus1.A = 1'b1; bus1.B = 1'b1; bus1.C = 1'b1;
      tick();
      bus1.start = 1'b0; bus1.A = 1'b0; bus1.B = 1'b0; bus1.C = 1'b0;
      check("w1_busy", 32'(bus1.busy), 32'd1);
      check("w1_nodone", 32'(bus1.done), 32'd0);
      tick();
      check("w1_done", 32'(bus1.done), 32'd1);
      check("w1_S", 32'(bus1.S), 32'd1);
      check("w1_Carry", 32'(bus1.Carry), 32'd1);
      tick();
      check("w1_done_end", 32'(bus1.done), 32'd0);
      check("w1_hold_S", 32'(bus1.S), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result bit width (legal range 1..32).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: start  input  1  request to begin one addition; sampled on rising clk.
REQ-005 Port: A  input  WIDTH  first operand; sampled only when start is accepted.
REQ-006 Port: B  input  WIDTH  second operand; sampled only when start is accepted.
REQ-007 Port: C  input  1  carry-in; sampled only when start is accepted.
REQ-008 Port: busy  output  1  high while an addition is in progress.
REQ-009 Port: done  output  1  one-cycle pulse marking that S/Carry hold a new result.
REQ-010 Port: S  output  WIDTH  registered sum of the last completed addition.
REQ-011 Port: Carry  output  1  registered carry-out of the last completed addition.

Function
REQ-012 The block SHALL contain exactly one FullAdder instance as its only adder, reused once per bit, LSB first.
REQ-013 FSM states SHALL be IDLE, RUN, DONE; encoding is free.
REQ-014 IDLE: start=1 SHALL latch A, B into operand shift registers and C into the carry register, clear the bit counter, and move to RUN; start=0 SHALL stay in IDLE.
REQ-015 RUN, each cycle: operand LSBs plus carry register SHALL feed the FullAdder; its sum SHALL shift into the result register from the MSB side; its carry SHALL load the carry register; operands SHALL shift right by one; the counter SHALL increment.
REQ-016 After WIDTH RUN cycles, the FSM SHALL move to DONE, load S from the result register and Carry from the final carry in the same edge.
REQ-017 Latency: if start is accepted at edge k, done SHALL be high in exactly the cycle after edge k+WIDTH; busy SHALL be high in the cycles after edges k..k+WIDTH-1.
REQ-018 DONE SHALL last exactly one cycle with done=1, busy=0, then go to IDLE unless start=1.
REQ-019 Start accepted in DONE SHALL behave as in IDLE, giving back-to-back operation with no idle cycle.
REQ-020 start SHALL be ignored while in RUN; A, B, C changes during RUN SHALL NOT affect the result.
REQ-021 S and Carry SHALL change only on the DONE transition and hold their value otherwise, including during a following RUN.
REQ-022 Result SHALL equal (A + B + C) mod 2^WIDTH in S, with bit WIDTH of the full sum in Carry.
REQ-023 WIDTH=1 SHALL work: one RUN cycle, then DONE.
REQ-024 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within one operation.

Reset
REQ-025 rst=1 SHALL, without waiting for clk, force state IDLE, busy=0, done=0, S=0, Carry=0, and clear the counter, shift and carry registers.
REQ-026 rst asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL run normally.
REQ-027 start high in the same cycle rst deasserts SHALL be accepted on the next rising edge at which rst is low.

Verification
REQ-028 WIDTH=8, A=8'hFF, B=8'h01, C=0, one-cycle start -> done pulses 8 cycles after the start edge; S=8'h00, Carry=1; busy high for 8 cycles.
REQ-029 WIDTH=8, A=8'h5A, B=8'h33, C=1 -> S=8'h8E, Carry=0; S/Carry unchanged for 10 further cycles with start low.
REQ-030 Start held high for 20 cycles with A=8'h10, B=8'h20, C=0 -> back-to-back results S=8'h30, Carry=0 every 9 cycles; mid-RUN operand changes ignored.
REQ-031 rst pulsed at the 3rd RUN cycle -> busy=0, done=0, S=0, Carry=0 immediately; no done pulse follows; next op A=8'h80, B=8'h80, C=1 -> S=8'h01, Carry=1.
REQ-032 WIDTH=1 build: A=1, B=1, C=1 -> done 1 cycle after start edge; S=1, Carry=1.
REQ-033 Random: 1000 ops with random A, B, C, WIDTH=8 -> every result matches A+B+C; exactly one done per accepted start.
